// File: rtl/aq_djpeg_coef_reorder.sv
// aq_djpeg_coef_reorder
// Coefficient reorder buffer between the Huffman decoder and the iDCT.
// Coefficients arrive tagged with their zigzag index and are stored in
// natural order in one of NUM_BANKS 64-entry banks. Completed blocks are
// handed out in FIFO order, two coefficients per read, with a one-cycle
// registered read port. Entries never written in a block read back as zero.
//
// Build option: define AQ_DJPEG_REORDER_TRANSPOSE_EN to store blocks in
// column-major (transposed) order for a column-first iDCT.
module aq_djpeg_coef_reorder #(
  parameter int DATA_W    = 16,
  parameter int NUM_BANKS = 2,
  parameter int COLOR_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               DataInit,
  input  logic               DataInEnable,
  input  logic [5:0]         DataInAddress,
  input  logic [DATA_W-1:0]  DataIn,
  input  logic [COLOR_W-1:0] DataInColor,
  input  logic               DataInEnd,
  output logic               DataInReady,
  output logic               DataOutEnable,
  output logic [COLOR_W-1:0] DataOutColor,
  input  logic [4:0]         DataOutAddress,
  input  logic               DataOutRead,
  output logic [DATA_W-1:0]  DataOutA,
  output logic [DATA_W-1:0]  DataOutB,
  output logic               ErrOverflow
);

  localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int FC_W  = $clog2(NUM_BANKS + 1);
  localparam logic [PTR_W-1:0] LAST_BANK = PTR_W'(NUM_BANKS - 1);
  localparam logic [FC_W-1:0]  FULL_CNT  = FC_W'(NUM_BANKS);

  // Zigzag scan position -> natural (row-major) index.
  localparam logic [5:0] ZZ_ROM [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Pair storage: element [0] holds the even natural index, [1] the odd one.
  logic [1:0][DATA_W-1:0] mem [NUM_BANKS][32];
  logic [63:0]            validMap [NUM_BANKS];
  logic [COLOR_W-1:0]     colorReg [NUM_BANKS];

  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W-1:0] wpNext;
  logic [PTR_W-1:0] rpNext;
  logic [FC_W-1:0]  fc;
  logic [5:0]       rowIdx;
  logic [5:0]       natIdx;
  logic             wrAccept;
  logic             endAccept;
  logic             relAccept;
  logic             endFills;

  assign DataInReady   = (fc < FULL_CNT);
  assign DataOutEnable = (fc != '0);
  assign DataOutColor  = DataOutEnable ? colorReg[rp] : '0;

  assign rowIdx = ZZ_ROM[DataInAddress];
`ifdef AQ_DJPEG_REORDER_TRANSPOSE_EN
  // Swap row and column so pairs run down the columns.
  assign natIdx = {rowIdx[2:0], rowIdx[5:3]};
`else
  assign natIdx = rowIdx;
`endif

  assign wrAccept  = DataInEnable && DataInReady && !DataInit;
  assign endAccept = DataInEnd && DataInReady && !DataInit;
  assign relAccept = DataOutRead && DataOutEnable && !DataInit;

  assign wpNext = (wp == LAST_BANK) ? '0 : wp + 1'b1;
  assign rpNext = (rp == LAST_BANK) ? '0 : rp + 1'b1;

  // When this end strobe fills the last free bank, the new write bank is the
  // head bank still waiting to be read, so its valid map must be preserved.
  assign endFills = (fc == FULL_CNT - 1'b1) && !relAccept;

  // Bank control: pointers, fill count, valid maps, colour tags, overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp          <= '0;
      rp          <= '0;
      fc          <= '0;
      ErrOverflow <= 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        validMap[i] <= '0;
        colorReg[i] <= '0;
      end
    end else if (DataInit) begin
      wp          <= '0;
      rp          <= '0;
      fc          <= '0;
      ErrOverflow <= 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        validMap[i] <= '0;
      end
    end else begin
      if ((DataInEnable || DataInEnd) && !DataInReady) begin
        ErrOverflow <= 1'b1;
      end
      // A released bank is free again; clearing it here keeps every free
      // bank empty, including the one that sat under wp while the buffer
      // was full.
      if (relAccept) begin
        validMap[rp] <= '0;
        rp           <= rpNext;
      end
      if (endAccept) begin
        colorReg[wp] <= DataInColor;
        wp           <= wpNext;
        if (!endFills) begin
          validMap[wpNext] <= '0;
        end
      end
      // A write in the same cycle as the end strobe belongs to the closing bank.
      if (wrAccept) begin
        validMap[wp][natIdx] <= 1'b1;
      end
      case ({endAccept, relAccept})
        2'b10:   fc <= fc + 1'b1;
        2'b01:   fc <= fc - 1'b1;
        default: fc <= fc;
      endcase
    end
  end

  // Coefficient storage write port (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wp][natIdx[5:1]][natIdx[0]] <= DataIn;
    end
  end

  // ---- read stage: registered pair output from the head bank ----
  // Unwritten entries are masked to zero by the valid map.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DataOutA <= '0;
      DataOutB <= '0;
    end else if (DataInit) begin
      DataOutA <= '0;
      DataOutB <= '0;
    end else begin
      DataOutA <= validMap[rp][{DataOutAddress, 1'b0}] ? mem[rp][DataOutAddress][0] : '0;
      DataOutB <= validMap[rp][{DataOutAddress, 1'b1}] ? mem[rp][DataOutAddress][1] : '0;
    end
  end

endmodule

// File: doc/aq_djpeg_coef_reorder.md
# aq_djpeg_coef_reorder

Parametrised coefficient reorder buffer between the Huffman decoder and the iDCT. It accepts decoded coefficients tagged with their zigzag index and collects them into one of `NUM_BANKS` 64-entry banks, storing each in natural (row-major) order. Indices that are never written read back as zero. Completed blocks are presented two coefficients per read, in FIFO order, with a full/free handshake. It supersedes the fixed two-bank zigzag stage with configurable width and depth, back-pressure and an overflow flag.

## Interface
Parameters:
- `DATA_W`, 16, coefficient width in bits.
- `NUM_BANKS`, 2, number of 64-entry block banks; legal values are 2 to 4.
- `COLOR_W`, 3, width of the component/colour tag.

Ports:
- `clk` input 1: the single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `DataInit` input 1: synchronous flush of all state.
- `DataInEnable` input 1: coefficient write strobe.
- `DataInAddress` input 6: zigzag index of the coefficient, 0 to 63.
- `DataIn` input `DATA_W`: coefficient value.
- `DataInColor` input `COLOR_W`: colour tag of the block.
- `DataInEnd` input 1: end-of-block strobe; closes the current write bank.
- `DataInReady` output 1: a write bank is free.
- `DataOutEnable` output 1: a completed bank is readable.
- `DataOutColor` output `COLOR_W`: colour tag of the head bank.
- `DataOutAddress` input 5: coefficient-pair index, 0 to 31.
- `DataOutRead` input 1: one-cycle pulse that releases the head bank.
- `DataOutA` output `DATA_W`: coefficient at natural index 2·addr.
- `DataOutB` output `DATA_W`: coefficient at natural index 2·addr+1.
- `ErrOverflow` output 1: sticky flag for input dropped while `DataInReady`=0.

## Operation
- **Storage:** each bank holds 32 pairs of `DATA_W` bits plus a 64-bit valid map, one bit per natural index.
- **Pointers:** write pointer `wp`, read pointer `rp`, and full count `fc` (0 to `NUM_BANKS`). Both pointers wrap modulo `NUM_BANKS`.
- **Write path:**
  - A fixed ROM maps the zigzag index to a natural index n.
  - On `DataInEnable`&&`DataInReady`, the value is written at n in bank `wp` and valid[n] is set.
  - If the same index is written twice, the last write wins.
- **End of block:** on `DataInEnd`&&`DataInReady`:
  - The bank's colour is latched from `DataInColor`.
  - `wp` increments and `fc` increments.
  - The valid map of the new `wp` bank is cleared in the same edge.
  - An end strobe with no preceding writes produces an all-zero block.
- **Same-cycle write and end:** the write belongs to the bank being closed.
- **Readiness:** `DataInReady` = (`fc` < `NUM_BANKS`). When `fc` = `NUM_BANKS`, writes and end strobes are ignored and set `ErrOverflow`.
- **Read path:**
  - `DataOutEnable` = (`fc` != 0).
  - Output data come from bank `rp`. An entry whose valid bit is 0 reads as 0.
- **Release:** `DataOutRead` while `DataOutEnable`=1 increments `rp` and decrements `fc`. `DataOutRead` while `DataOutEnable`=0 is ignored.
- **Simultaneous release and end:** `fc` is unchanged and both pointers advance.
- **`DataInit`:** overrides every other input. It clears the pointers, `fc`, all valid maps and `ErrOverflow`. Stored data need not be cleared.

## Timing
- **Reset values:** `DataInReady`=1, `DataOutEnable`=0, `DataOutColor`=0, `DataOutA`=`DataOutB`=0, `ErrOverflow`=0, and all pointers and the count are 0.
- **Write:** data are captured on the edge where the strobe is sampled.
- **End to readable:** `DataInEnd` sampled at edge N gives `DataOutEnable`=1 after edge N, provided the buffer was empty.
- **Read data:** registered with one-cycle latency. `DataOutAddress` sampled at edge N gives `DataOutA`/`DataOutB` valid after edge N, from the bank that was `rp` at edge N.
- **Release:** `DataOutRead` at edge N changes `DataOutEnable`/`DataOutColor` after edge N.
- **Freeing space:** `DataInReady` rises in the cycle after the release that frees a bank. The input side may then write in that same cycle.
- **Throughput:** one coefficient write per cycle, and one pair read per cycle. A full block drains in 32 cycles.
- **Reset:** asserting `rst` mid-block discards that block immediately.

## Configuration
- **`AQ_DJPEG_REORDER_TRANSPOSE_EN`:**
  - Defined: the zigzag ROM emits the transposed natural index (column-major), so `DataOutA`/`DataOutB` pairs run down the columns, which the column-first iDCT needs.
  - Undefined: row-major order.
  - All other behaviour is identical.

## Test plan
- **Full ordered block:** after reset, write zigzag indices 0 to 63 with value = index+100, then pulse `DataInEnd`. Reading addresses 0 to 31 must return the natural-order values. For example, address 0 gives A=100 and B=101 (natural 1 = zigzag 1). Address 1 gives A=105 (zigzag 5) and B=106 (zigzag 6).
- **Sparse block:** write only index 0 = 0x7FF and index 2 = −5, then pulse `DataInEnd`. Address 0 must return A=0x7FF and B=0. Address 4 (natural 8 = zigzag 2) must return A=−5. Every other entry must read 0.
- **Overflow:** with `NUM_BANKS`=2, close 2 blocks without reading. `DataInReady` must go to 0. Then write index 0 = 55 and close a third block. `ErrOverflow` must go to 1, and `fc` must stay at 2. The first block must read unchanged.
- **Simultaneous release and end:** with 1 bank full, assert `DataOutRead` and `DataInEnd` together. `DataOutEnable` must stay 1, and the colour must switch to the new bank's tag (for example 3 to 5).
- **`DataInit` flush:** fill 2 banks, then pulse `DataInit`. `DataOutEnable`=0, `DataInReady`=1 and `ErrOverflow`=0 must hold the next cycle. The next block, with no writes, must read all zeros.
- **Transpose build:** with `AQ_DJPEG_REORDER_TRANSPOSE_EN` defined, write zigzag 1 = 9 (natural row 0, column 1). Address 4 must return A=9.
